// File: rtl/stream_source.sv
// Valid/ready burst source: incrementing-count or 32-bit Galois LFSR payload, backpressure-safe.
// Define STREAM_SOURCE_THROTTLE_EN to honour the per-beat idle gap (GAP state + gap counter).
module stream_source #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [3:0]        gap,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sent_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(32'h8020_0003);

    state_t            r_state, w_state_nxt;
    logic              r_valid, w_valid_nxt;
    logic [DATA_W-1:0] r_data,  w_data_nxt;
    logic              r_busy,  w_busy_nxt;
    logic              r_done,  w_done_nxt;
    logic [CNT_W-1:0]  r_sent,  w_sent_nxt;
    logic [CNT_W-1:0]  r_remain, w_remain_nxt;
    logic              r_mode,  w_mode_nxt;
    logic              w_beat;
    logic [DATA_W-1:0] w_adv;

`ifdef STREAM_SOURCE_THROTTLE_EN
    logic [3:0]        r_gap,     w_gap_nxt;
    logic [3:0]        r_gap_cnt, w_gap_cnt_nxt;
`else
    logic              w_unused_gap;
    assign w_unused_gap = |gap;
`endif

    always_comb begin
        w_beat = r_valid & out_ready;
        if (r_mode) begin
            w_adv = r_data[0] ? ((r_data >> 1) ^ LFSR_TAPS) : (r_data >> 1);
        end else begin
            w_adv = r_data + DATA_W'(1);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_valid_nxt  = r_valid;
        w_data_nxt   = r_data;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_sent_nxt   = r_sent;
        w_remain_nxt = r_remain;
        w_mode_nxt   = r_mode;
`ifdef STREAM_SOURCE_THROTTLE_EN
        w_gap_nxt     = r_gap;
        w_gap_cnt_nxt = r_gap_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        w_remain_nxt = len;
                        w_mode_nxt   = mode;
`ifdef STREAM_SOURCE_THROTTLE_EN
                        w_gap_nxt    = gap;
`endif
                        // An all-zero LFSR state would lock up, so substitute 1.
                        w_data_nxt   = (mode && seed == '0) ? DATA_W'(1) : seed;
                        w_sent_nxt   = '0;
                        w_busy_nxt   = 1'b1;
                        w_valid_nxt  = 1'b1;
                        w_state_nxt  = S_SEND;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_SEND: begin
                if (w_beat) begin
                    w_sent_nxt   = r_sent + CNT_W'(1);
                    w_remain_nxt = r_remain - CNT_W'(1);
                    w_data_nxt   = w_adv;
                    if (r_remain == CNT_W'(1)) begin
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
`ifdef STREAM_SOURCE_THROTTLE_EN
                    end else if (r_gap != '0) begin
                        w_valid_nxt   = 1'b0;
                        w_gap_cnt_nxt = r_gap;
                        w_state_nxt   = S_GAP;
`endif
                    end
                end
            end
            S_GAP: begin
`ifdef STREAM_SOURCE_THROTTLE_EN
                // Counter holds the cycles still to idle, so leave when one remains.
                if (r_gap_cnt == 4'd1) begin
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_SEND;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 4'd1;
                end
`else
                w_state_nxt = S_IDLE;
`endif
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sent   <= '0;
            r_remain <= '0;
            r_mode   <= 1'b0;
`ifdef STREAM_SOURCE_THROTTLE_EN
            r_gap     <= '0;
            r_gap_cnt <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_valid  <= w_valid_nxt;
            r_data   <= w_data_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_sent   <= w_sent_nxt;
            r_remain <= w_remain_nxt;
            r_mode   <= w_mode_nxt;
`ifdef STREAM_SOURCE_THROTTLE_EN
            r_gap     <= w_gap_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
`endif
        end
    end

    assign out_valid  = r_valid;
    assign data_out   = r_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign sent_count = r_sent;

endmodule

// File: tb/tb_stream_source.sv
// Directed bench for stream_source: vector table plus backpressure, throttle, len=0 and async-reset sequences.
module tb_stream_source;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  len;
    logic              mode;
    logic [DATA_W-1:0] seed;
    logic [3:0]        gap;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] data_out;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  sent_count;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    stream_source #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .mode       (mode),
        .seed       (seed),
        .gap        (gap),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .busy       (busy),
        .done       (done),
        .sent_count (sent_count)
    );

    typedef struct {
        logic        st;
        logic [15:0] ln;
        logic        md;
        logic [31:0] sd;
        logic        rdy;
        logic        ev;
        logic        eb;
        logic        ed;
        logic [15:0] es;
        logic [31:0] edat;
    } vec_t;

    vec_t vecs [21];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pk(input logic v, input logic b, input logic d,
                                       input logic [15:0] s, input logic [31:0] dat);
        return {13'd0, v, b, d, s, dat};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h ({valid,busy,done,sent,data})", nm, act, exp);
    endtask

    task automatic chk_out(input string nm, input logic v, input logic b, input logic d,
                           input logic [15:0] s, input logic [31:0] dat);
        chk(nm, pk(out_valid, busy, done, sent_count, data_out), pk(v, b, d, s, dat));
    endtask

    task automatic drive(input logic st, input logic [15:0] ln, input logic md,
                         input logic [31:0] sd, input logic rdy);
        start = st; len = ln; mode = md; seed = sd; out_ready = rdy;
    endtask

    initial begin : main
        logic [7:0] got_v, got_d, exp_v, exp_d;
        int beats;

        //           st    len    md    seed          rdy   v     b     d     sent   data
        vecs[0]  = '{1'b1, 16'd5, 1'b0, 32'h10,       1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 32'h10};
        vecs[1]  = '{1'b0, 16'd0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 16'd1, 32'h11};
        vecs[2]  = '{1'b0, 16'd0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 16'd2, 32'h12};
        vecs[3]  = '{1'b0, 16'd0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 16'd3, 32'h13};
        vecs[4]  = '{1'b0, 16'd0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 16'd4, 32'h14};
        vecs[5]  = '{1'b0, 16'd0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 16'd5, 32'h15};
        vecs[6]  = '{1'b0, 16'd0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 16'd5, 32'h15};
        vecs[7]  = '{1'b1, 16'd4, 1'b1, 32'h1,        1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 32'h1};
        vecs[8]  = '{1'b0, 16'd0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 16'd1, 32'h80200003};
        vecs[9]  = '{1'b0, 16'd0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 16'd2, 32'hC0300002};
        vecs[10] = '{1'b0, 16'd0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 16'd3, 32'h60180001};
        vecs[11] = '{1'b0, 16'd0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 16'd4, 32'hB02C0003};
        vecs[12] = '{1'b0, 16'd0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 16'd4, 32'hB02C0003};
        vecs[13] = '{1'b1, 16'd1, 1'b1, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 32'h1};
        vecs[14] = '{1'b0, 16'd0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 32'h80200003};
        vecs[15] = '{1'b0, 16'd0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 32'h80200003};
        vecs[16] = '{1'b1, 16'd3, 1'b0, 32'h100,      1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 32'h100};
        vecs[17] = '{1'b1, 16'd9, 1'b0, 32'h500,      1'b1, 1'b1, 1'b1, 1'b0, 16'd1, 32'h101};
        vecs[18] = '{1'b0, 16'd0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 16'd2, 32'h102};
        vecs[19] = '{1'b0, 16'd0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 16'd3, 32'h103};
        vecs[20] = '{1'b0, 16'd0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 32'h103};

        rst = 1'b0;
        gap = 4'd0;
        drive(1'b0, 16'd0, 1'b0, 32'h0, 1'b0);
        step();
        step();
        chk_out("reset_state", 1'b0, 1'b0, 1'b0, 16'd0, 32'h0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].st, vecs[i].ln, vecs[i].md, vecs[i].sd, vecs[i].rdy);
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eb, vecs[i].ed, vecs[i].es, vecs[i].edat);
        end

        // Backpressure across the 0xFFFFFFFF -> 0 wrap.
        drive(1'b1, 16'd3, 1'b0, 32'hFFFFFFFF, 1'b1);
        step();
        chk_out("bp_first", 1'b1, 1'b1, 1'b0, 16'd0, 32'hFFFFFFFF);
        drive(1'b0, 16'd0, 1'b0, 32'h0, 1'b1);
        step();
        chk_out("bp_wrap", 1'b1, 1'b1, 1'b0, 16'd1, 32'h0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("bp_stall%0d", i), 1'b1, 1'b1, 1'b0, 16'd1, 32'h0);
        end
        out_ready = 1'b1;
        step();
        chk_out("bp_resume", 1'b1, 1'b1, 1'b0, 16'd2, 32'h1);
        step();
        chk_out("bp_done", 1'b0, 1'b0, 1'b1, 16'd3, 32'h2);
        step();

        // Throttle: len=3, gap=2, start at edge k; index i records the cycle after edge k+i.
        gap = 4'd2;
        drive(1'b1, 16'd3, 1'b0, 32'h40, 1'b1);
        step();
        got_v[0] = out_valid;
        got_d[0] = done;
        drive(1'b0, 16'd0, 1'b0, 32'h0, 1'b1);
        for (int i = 1; i < 8; i++) begin
`ifdef STREAM_SOURCE_THROTTLE_EN
            out_ready = (i == 2 || i == 5) ? 1'b0 : 1'b1;
`endif
            step();
            got_v[i] = out_valid;
            got_d[i] = done;
        end
`ifdef STREAM_SOURCE_THROTTLE_EN
        exp_v = 8'b0100_1001;
        exp_d = 8'b1000_0000;
`else
        exp_v = 8'b0000_0111;
        exp_d = 8'b0000_1000;
`endif
        chk("throttle_valid", {56'd0, got_v}, {56'd0, exp_v});
        chk("throttle_done", {56'd0, got_d}, {56'd0, exp_d});
        out_ready = 1'b1;
        gap = 4'd0;
        step();
        step();

        // len = 0: no beat, done the cycle after start.
        drive(1'b1, 16'd0, 1'b0, 32'h99, 1'b1);
        step();
        chk("len0_pulse", {61'd0, out_valid, busy, done}, {61'd0, 3'b001});
        drive(1'b0, 16'd0, 1'b0, 32'h0, 1'b1);
        step();
        chk("len0_after", {61'd0, out_valid, busy, done}, {61'd0, 3'b000});
        step();

        // Asynchronous reset during the third beat of a len=8 burst.
        drive(1'b1, 16'd8, 1'b0, 32'h0, 1'b1);
        step();
        drive(1'b0, 16'd0, 1'b0, 32'h0, 1'b1);
        step();
        step();
        chk_out("ar_third_beat", 1'b1, 1'b1, 1'b0, 16'd2, 32'h2);
        #2;
        rst = 1'b0;
        #1;
        chk_out("ar_immediate", 1'b0, 1'b0, 1'b0, 16'd0, 32'h0);
        step();
        step();
        chk_out("ar_held", 1'b0, 1'b0, 1'b0, 16'd0, 32'h0);
        #3;
        rst = 1'b1;
        step();
        drive(1'b1, 16'd2, 1'b0, 32'h77, 1'b1);
        beats = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            start = 1'b0;
            if (out_valid && out_ready) beats++;
        end
        chk("ar_restart_beats", 64'(beats), 64'd2);
        chk_out("ar_restart_final", 1'b0, 1'b0, 1'b0, 16'd2, 32'h79);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stream_source.md
# stream_source

Valid/ready transmitter that produces a programmable burst of DATA_W-bit words on a stream interface, for driving the input side of the pipeline stages in this design. Words are either an incrementing count or a 32-bit Galois LFSR sequence from a loaded seed. The source holds valid and data stable under backpressure. With the throttle feature compiled in, it can insert idle gaps between beats.

## Interface
- DATA_W, 32, payload width; the LFSR mode requires 32.
- CNT_W, 16, width of the burst length and beat counter.
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
- len  input  CNT_W  number of beats in the burst; latched on an accepted start.
- mode  input  1  payload pattern: 0 = incrementing counter, 1 = LFSR; latched on start.
- seed  input  DATA_W  first payload word; latched on start.
- gap  input  4  idle cycles inserted after each non-final beat; latched on start; used only with throttle.
- out_valid  output  1  payload valid.
- out_ready  input  1  sink ready.
- data_out  output  DATA_W  payload.
- busy  output  1  high from an accepted start until the burst completes.
- done  output  1  one-cycle pulse when the burst completes.
- sent_count  output  CNT_W  beats accepted in the current or last burst.

## Operation
- All outputs are registered.
- Reset values of every output: out_valid=0, data_out=0, busy=0, done=0, sent_count=0.
- Reset puts the FSM in IDLE.
- The FSM has four states: IDLE, SEND, GAP and DONE.
- IDLE, start=1, len!=0:
  - latch len, mode, seed and gap;
  - set data_out=seed; if mode=1 and seed=0, set data_out=1;
  - clear sent_count, set busy=1;
  - go to SEND.
- IDLE, start=1, len=0: go to DONE; no beat is issued.
- start is ignored in every state except IDLE.
- SEND: out_valid=1. A beat is a cycle with out_valid && out_ready. On each beat:
  - sent_count increments and the remaining count decrements;
  - the payload advances:
    - mode 0: data_out+1, wrapping modulo 2^DATA_W (0xFFFFFFFF -> 0x00000000);
    - mode 1: if bit0=1, next = (x>>1) ^ 0x80200003; otherwise next = x>>1.
- SEND transitions:
  - remaining reaches 0 -> DONE;
  - otherwise, gap!=0 (throttle only) -> GAP with the gap counter loaded from gap;
  - otherwise stay in SEND for back-to-back beats.
- While in SEND without a beat, out_valid stays 1 and data_out stays stable. Valid is never withdrawn before a beat.
- GAP: out_valid=0. The gap counter decrements each cycle and the FSM returns to SEND after exactly gap cycles.
- DONE: done=1 for one cycle, busy=0, out_valid=0, then IDLE. sent_count holds its value until the next accepted start.

## Timing
- An accepted start at edge k drives out_valid=1 in the cycle after edge k.
- First-beat latency is 1 cycle from start.
- With gap=0 and out_ready held high, throughput is one beat per cycle with no bubbles.
- The next payload value is visible in the cycle after its beat.
- done is asserted in the cycle after the final beat, or in the cycle after start when len=0.
- busy deasserts in the same cycle done asserts.
- A new start is accepted at the earliest in the cycle after the done pulse.
- Reset asserted mid-burst clears out_valid, busy and state immediately, without waiting for a clock edge. After reset deasserts, a fresh start behaves normally.
- out_ready toggling during GAP has no effect.

## Configuration
- Macro: STREAM_SOURCE_THROTTLE_EN.
- Defined:
  - the GAP state and the gap counter exist;
  - gap is latched and honoured after every non-final beat.
- Undefined:
  - the gap port remains but is ignored;
  - the GAP state is never entered, so beats are always back-to-back subject to out_ready.

## Test plan
- Counter burst: reset, then start with len=5, mode=0, seed=0x10, gap=0, out_ready=1 -> data 0x10..0x14 on five consecutive cycles starting one cycle after start; done one cycle after 0x14; sent_count=5.
- Backpressure: len=3, mode=0, seed=0xFFFFFFFF, out_ready low for 3 cycles after the first beat -> out_valid stays 1 and data_out holds 0x00000000 while stalled; the sequence is 0xFFFFFFFF, 0x00000000, 0x00000001 with no duplicates or skips.
- LFSR: mode=1, seed=1, len=4 -> 0x00000001, 0x80200003, 0xC0300002, 0x60180001. With seed=0 the first word is 0x00000001.
- Throttle (macro defined): len=3, gap=2, out_ready=1, start at edge k -> out_valid high only in the cycles after edges k, k+3 and k+6.
- Throttle (macro undefined): same stimulus -> out_valid high in the cycles after edges k, k+1 and k+2.
- Corner cases:
  - len=0 -> no out_valid; done pulses in the cycle after start.
  - start while busy -> ignored; the burst length is unchanged.
- Async reset: assert rst low between clock edges during the third beat of a len=8 burst -> out_valid and busy go 0 immediately; after release, start with len=2 sends exactly 2 beats.
